// File: rtl/scan_decoder.sv
// One-hot channel select decoder with an autonomous display-scan engine.
// Direct mode registers a decode of sel; scan mode walks every channel with dwell, blanking and a mask.
module scan_decoder #(
   parameter int SEL_W      = 3,
   parameter int CHANNELS   = 8,
   parameter int PRESCALE   = 100000,
   parameter int BLANK      = 0,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                mode,
   input  logic [SEL_W-1:0]    sel,
   input  logic [CHANNELS-1:0] mask,
   output logic [CHANNELS-1:0] yout,
   output logic [SEL_W-1:0]    idx,
   output logic                frame
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]       PCNT_LAST  = PW'(PRESCALE - 1);
   localparam logic [PW-1:0]       BLANK_LAST = (BLANK > 0) ? PW'(BLANK - 1) : '0;
   localparam logic [SEL_W-1:0]    IDX_LAST   = SEL_W'(CHANNELS - 1);
   localparam logic [CHANNELS-1:0] INACTIVE   = (ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic [1:0] {
      ST_OFF,
      ST_DIRECT,
      ST_BLANK,
      ST_DRIVE
   } state_t;

   // With no blank interval a slot opens directly in the driving state.
   localparam state_t SLOT_FIRST = (BLANK == 0) ? ST_DRIVE : ST_BLANK;

   state_t              state_q, state_d;
   logic [PW-1:0]       pcnt_q, pcnt_d;
   logic [SEL_W-1:0]    idx_q, idx_d;
   logic                frame_q, frame_d;
   logic [CHANNELS-1:0] yout_q, yout_d;
   logic [SEL_W-1:0]    idx_next;

   // Out-of-range indices and masked channels both decode to all-inactive.
   function automatic logic [CHANNELS-1:0] decode(input logic [SEL_W-1:0] n,
                                                  input logic [CHANNELS-1:0] m);
      logic [CHANNELS-1:0] hot;
      hot = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         hot[i] = (n == SEL_W'(i)) && m[i];
      end
      return (ACTIVE_LOW != 0) ? ~hot : hot;
   endfunction

   always_comb begin
      state_d  = state_q;
      pcnt_d   = pcnt_q;
      idx_d    = idx_q;
      frame_d  = 1'b0;
      yout_d   = INACTIVE;
      idx_next = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

      if (!en) begin
         state_d = ST_OFF;
         pcnt_d  = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_OFF, ST_DIRECT: begin
               state_d = mode ? SLOT_FIRST : ST_DIRECT;
               pcnt_d  = '0;
               idx_d   = '0;
            end
            ST_BLANK: begin
               if (!mode) begin
                  state_d = ST_DIRECT;
                  pcnt_d  = '0;
                  idx_d   = '0;
               end else begin
                  pcnt_d = pcnt_q + 1'b1;
                  if (pcnt_q == BLANK_LAST) begin
                     state_d = ST_DRIVE;
                  end
               end
            end
            ST_DRIVE: begin
               if (!mode) begin
                  state_d = ST_DIRECT;
                  pcnt_d  = '0;
                  idx_d   = '0;
               end else if (pcnt_q == PCNT_LAST) begin
                  state_d = SLOT_FIRST;
                  pcnt_d  = '0;
                  idx_d   = idx_next;
                  frame_d = (idx_q == IDX_LAST);
               end else begin
                  pcnt_d = pcnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_OFF;
               pcnt_d  = '0;
               idx_d   = '0;
            end
         endcase
      end

      // Output follows the state being entered so every output stays registered.
      case (state_d)
         ST_DIRECT: yout_d = decode(sel, mask);
         ST_DRIVE:  yout_d = decode(idx_d, mask);
         default:   yout_d = INACTIVE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_OFF;
         pcnt_q  <= '0;
         idx_q   <= '0;
         frame_q <= 1'b0;
         yout_q  <= INACTIVE;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         idx_q   <= idx_d;
         frame_q <= frame_d;
         yout_q  <= yout_d;
      end
   end

   assign yout  = yout_q;
   assign idx   = idx_q;
   assign frame = frame_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: three instances (4 channels, 3 channels, 1-cycle slots)
// share stimulus; a cycle-count reference model feeds a scoreboard queue.
module tb_scan_decoder;

   typedef struct packed {
      logic [3:0] yout;
      logic [1:0] idx;
      logic       frame;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       en;
   logic       mode;
   logic [1:0] sel;
   logic [3:0] mask;

   logic [3:0] yout0, yout1;
   logic [2:0] yout3;
   logic [1:0] idx0, idx3, idx1;
   logic       frame0, frame3, frame1;

   int   nChecks = 0;
   int   nFail   = 0;
   exp_t sb[$];

   int   prescaleOf[3] = '{4, 4, 1};
   int   blankOf[3]    = '{1, 1, 0};
   int   chanOf[3]     = '{4, 3, 4};
   bit   scanM[3];
   int   cntM[3];

   scan_decoder #(.SEL_W(2), .CHANNELS(4), .PRESCALE(4), .BLANK(1), .ACTIVE_LOW(1)) dut0 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel), .mask(mask),
      .yout(yout0), .idx(idx0), .frame(frame0));

   scan_decoder #(.SEL_W(2), .CHANNELS(3), .PRESCALE(4), .BLANK(1), .ACTIVE_LOW(1)) dut3 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel), .mask(mask[2:0]),
      .yout(yout3), .idx(idx3), .frame(frame3));

   scan_decoder #(.SEL_W(2), .CHANNELS(4), .PRESCALE(1), .BLANK(0), .ACTIVE_LOW(1)) dut1 (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel), .mask(mask),
      .yout(yout1), .idx(idx1), .frame(frame1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Compares one observed value with the expected value and logs a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      nChecks++;
      if (got !== want) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
      end
   endtask

   function automatic logic [3:0] expDecode(input int n, input int c, input logic [3:0] m);
      logic [3:0] r;
      r = 4'hF;
      if (n < c && m[n]) r[n] = 1'b0;
      return r;
   endfunction

   // Reference model: position in a scan is derived purely from cycles since scan start.
   task automatic modelStep(input int k, input logic enI, input logic modeI,
                            input logic [1:0] selI, input logic [3:0] maskI, output exp_t e);
      int p, b, c, ch, pos;
      p = prescaleOf[k];
      b = blankOf[k];
      c = chanOf[k];
      e.yout  = 4'hF;
      e.idx   = 2'd0;
      e.frame = 1'b0;
      if (!enI) begin
         scanM[k] = 1'b0;
      end else if (!modeI) begin
         scanM[k] = 1'b0;
         e.yout   = expDecode(int'(selI), c, maskI);
      end else begin
         if (!scanM[k]) begin
            scanM[k] = 1'b1;
            cntM[k]  = 0;
         end else begin
            cntM[k]++;
         end
         ch      = (cntM[k] / p) % c;
         pos     = cntM[k] % p;
         e.idx   = 2'(ch);
         e.yout  = (pos < b) ? 4'hF : expDecode(ch, c, maskI);
         e.frame = (cntM[k] > 0) && (cntM[k] % (p * c) == 0);
      end
   endtask

   // Drives one cycle of inputs, queues the expectations, then checks after the edge.
   task automatic applyStimulus(input logic enI, input logic modeI,
                                input logic [1:0] selI, input logic [3:0] maskI);
      exp_t e;
      exp_t o;
      en   = enI;
      mode = modeI;
      sel  = selI;
      mask = maskI;
      for (int k = 0; k < 3; k++) begin
         modelStep(k, enI, modeI, selI, maskI, e);
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         e = sb.pop_front();
         case (k)
            0:       o = '{yout: yout0, idx: idx0, frame: frame0};
            1:       o = '{yout: {1'b1, yout3}, idx: idx3, frame: frame3};
            default: o = '{yout: yout1, idx: idx1, frame: frame1};
         endcase
         checkOutput($sformatf("yout[%0d]", k), 32'(o.yout), 32'(e.yout));
         checkOutput($sformatf("idx[%0d]", k), 32'(o.idx), 32'(e.idx));
         checkOutput($sformatf("frame[%0d]", k), 32'(o.frame), 32'(e.frame));
         checkOutput($sformatf("onehot[%0d]", k), 32'($countones(~o.yout) <= 1), 32'd1);
      end
   endtask

   initial begin
      bit hit;
      reset = 1'b1;
      en    = 1'b0;
      mode  = 1'b0;
      sel   = 2'd0;
      mask  = 4'hF;
      #3;
      checkOutput("rst_yout0", 32'(yout0), 32'hF);
      checkOutput("rst_yout3", 32'(yout3), 32'h7);
      checkOutput("rst_idx0", 32'(idx0), 32'd0);
      checkOutput("rst_frame0", 32'(frame0), 32'd0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;

      repeat (2) applyStimulus(1'b0, 1'b0, 2'd0, 4'hF);

      applyStimulus(1'b1, 1'b0, 2'd2, 4'hF);
      applyStimulus(1'b1, 1'b0, 2'd1, 4'b1101);
      applyStimulus(1'b1, 1'b0, 2'd3, 4'hF);
      applyStimulus(1'b1, 1'b0, 2'd0, 4'hF);

      repeat (20) applyStimulus(1'b1, 1'b1, 2'd0, 4'hF);
      repeat (16) applyStimulus(1'b1, 1'b1, 2'd0, 4'b0101);

      hit = 1'b0;
      for (int g = 0; g < 64 && !hit; g++) begin
         applyStimulus(1'b1, 1'b1, 2'd0, 4'hF);
         hit = scanM[0] && ((cntM[0] / 4) % 4 == 2) && (cntM[0] % 4 == 2);
      end
      checkOutput("reach_ch2_drive", 32'(hit), 32'd1);
      applyStimulus(1'b0, 1'b1, 2'd0, 4'hF);
      repeat (6) applyStimulus(1'b1, 1'b1, 2'd0, 4'hF);
      repeat (2) applyStimulus(1'b1, 1'b0, 2'd3, 4'hF);

      for (int g = 0; g < 40; g++) begin
         applyStimulus(($urandom_range(11, 0) != 0), ($urandom_range(7, 0) != 0),
                       2'($urandom_range(3, 0)), 4'($urandom_range(15, 0)));
      end

      hit = 1'b0;
      for (int g = 0; g < 32 && !hit; g++) begin
         applyStimulus(1'b1, 1'b1, 2'd0, 4'hF);
         hit = scanM[0] && (cntM[0] % 4 != 0);
      end
      checkOutput("reach_drive", 32'(hit), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_yout0", 32'(yout0), 32'hF);
      checkOutput("async_idx0", 32'(idx0), 32'd0);
      checkOutput("async_frame0", 32'(frame0), 32'd0);
      checkOutput("async_yout1", 32'(yout1), 32'hF);
      for (int k = 0; k < 3; k++) scanM[k] = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) applyStimulus(1'b0, 1'b1, 2'd0, 4'hF);
      repeat (18) applyStimulus(1'b1, 1'b1, 2'd0, 4'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
